// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   function automatic int unsigned offset_bits(input int unsigned bitsize,
                                               input int unsigned n_words);
      return $clog2(bitsize / 8) + $clog2(n_words);
   endfunction

   function automatic int unsigned index_bits(input int unsigned n_lines);
      return $clog2(n_lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned bitsize,
                                            input int unsigned n_words,
                                            input int unsigned n_lines);
      return 32 - offset_bits(bitsize, n_words) - index_bits(n_lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/data/valid storage: asynchronous read port, one line write port, clear-all.
module icache_array
   import icache_pkg::*;
#(
   parameter int unsigned BITSIZE          = 32,
   parameter int unsigned N_WORDS_PER_ADDR = 4,
   parameter int unsigned N_LINES          = 16,
   localparam int unsigned INDEX_W = index_bits(N_LINES),
   localparam int unsigned TAG_W   = tag_bits(BITSIZE, N_WORDS_PER_ADDR, N_LINES),
   localparam int unsigned LINE_W  = N_WORDS_PER_ADDR * BITSIZE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line,
   input  logic               wr_valid
);

   logic [N_LINES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem  [N_LINES];
   logic [LINE_W-1:0]  data_mem [N_LINES];

   // Clear wins over a same-cycle write so a flushed refill stays invalid.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, line refill on miss.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned BITSIZE          = 32,
   parameter int unsigned N_WORDS_PER_ADDR = 4,
   parameter int unsigned N_LINES          = 16
) (
   input  logic                                clk,
   input  logic                                reset_i,
   input  logic                                req_i,
   input  logic [31:0]                         addr_i,
   output logic                                ack_o,
   output logic [BITSIZE-1:0]                  data_o,
   input  logic                                flush_i,
   output logic [31:0]                         mem_addr_o,
   output logic                                mem_load_o,
   output logic                                mem_store_o,
   output logic [N_WORDS_PER_ADDR*BITSIZE-1:0] mem_data_o,
   input  logic [N_WORDS_PER_ADDR*BITSIZE-1:0] mem_data_i,
   input  logic                                mem_done_i,
   output logic [31:0]                         hit_cnt_o,
   output logic [31:0]                         miss_cnt_o
);

   localparam int unsigned BYTE_BITS = $clog2(BITSIZE / 8);
   localparam int unsigned WSEL_BITS = $clog2(N_WORDS_PER_ADDR);
   localparam int unsigned WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;
   localparam int unsigned OFF_BITS  = offset_bits(BITSIZE, N_WORDS_PER_ADDR);
   localparam int unsigned INDEX_W   = index_bits(N_LINES);
   localparam int unsigned TAG_W     = tag_bits(BITSIZE, N_WORDS_PER_ADDR, N_LINES);
   localparam int unsigned LINE_W    = N_WORDS_PER_ADDR * BITSIZE;

   state_t state, next_state;

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic [WSEL_W-1:0]  wsel;
   logic [31:0]        line_addr;

   logic [INDEX_W-1:0] cap_index;
   logic [TAG_W-1:0]   cap_tag;
   logic [WSEL_W-1:0]  cap_wsel;
   logic [31:0]        mem_addr_q;
   logic               flush_pending, pend_next;
   logic [31:0]        hit_cnt, miss_cnt;

   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [LINE_W-1:0]  rd_line;
   logic               arr_clear, wr_en, wr_valid;
   logic               hit, miss;

   assign index     = INDEX_W'(addr_i >> OFF_BITS);
   assign tag       = TAG_W'(addr_i >> (OFF_BITS + INDEX_W));
   assign line_addr = addr_i >> OFF_BITS;
   assign wsel      = (WSEL_BITS > 0) ? WSEL_W'(addr_i >> BYTE_BITS) : '0;

   function automatic logic [BITSIZE-1:0] pick(input logic [LINE_W-1:0] line,
                                               input logic [WSEL_W-1:0] sel);
      return line[sel*BITSIZE +: BITSIZE];
   endfunction

   icache_array #(
      .BITSIZE          (BITSIZE),
      .N_WORDS_PER_ADDR (N_WORDS_PER_ADDR),
      .N_LINES          (N_LINES)
   ) u_array (
      .clk      (clk),
      .reset    (reset_i),
      .clear    (arr_clear),
      .rd_index (index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_index (cap_index),
      .wr_tag   (cap_tag),
      .wr_line  (mem_data_i),
      .wr_valid (wr_valid)
   );

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
         mem_addr_q    <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         cap_index     <= '0;
         cap_tag       <= '0;
         cap_wsel      <= '0;
      end else begin
         state         <= next_state;
         flush_pending <= pend_next;
         if (hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (miss) begin
            miss_cnt   <= miss_cnt + 32'd1;
            cap_index  <= index;
            cap_tag    <= tag;
            cap_wsel   <= wsel;
            mem_addr_q <= line_addr;
         end
      end
   end

   always_comb begin
      next_state = state;
      pend_next  = flush_pending;
      ack_o      = 1'b0;
      data_o     = '0;
      mem_load_o = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;
      arr_clear  = 1'b0;
      wr_en      = 1'b0;
      wr_valid   = 1'b0;
      case (state)
         IDLE: begin
            arr_clear = flush_i;
            // A lookup coinciding with a flush must not see the soon-invalid line.
            if (req_i) begin
               if (!flush_i && rd_valid && (rd_tag == tag)) begin
                  hit    = 1'b1;
                  ack_o  = 1'b1;
                  data_o = pick(rd_line, wsel);
               end else begin
                  miss       = 1'b1;
                  next_state = REFILL;
               end
            end
         end
         REFILL: begin
            mem_load_o = 1'b1;
            if (flush_i) begin
               pend_next = 1'b1;
            end
            if (mem_done_i) begin
               wr_en      = 1'b1;
               wr_valid   = !(flush_pending || flush_i);
               arr_clear  = flush_pending || flush_i;
               pend_next  = 1'b0;
               ack_o      = 1'b1;
               data_o     = pick(mem_data_i, cap_wsel);
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign mem_addr_o  = mem_addr_q;
   assign mem_store_o = 1'b0;
   assign mem_data_o  = '0;
   assign hit_cnt_o   = hit_cnt;
   assign miss_cnt_o  = miss_cnt;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cache-level model compared every cycle plus literal pins.
module tb_icache;

   localparam int unsigned BITSIZE = 32;
   localparam int unsigned NW      = 4;
   localparam int unsigned NL      = 16;

   logic           clk = 1'b0;
   logic           reset_i, req_i, flush_i, mem_done_i;
   logic [31:0]    addr_i;
   logic           ack_o, mem_load_o, mem_store_o;
   logic [31:0]    data_o, mem_addr_o, hit_cnt_o, miss_cnt_o;
   logic [127:0]   mem_data_o, mem_data_i;

   always #5 clk = ~clk;

   icache #(
      .BITSIZE          (BITSIZE),
      .N_WORDS_PER_ADDR (NW),
      .N_LINES          (NL)
   ) dut (
      .clk        (clk),
      .reset_i    (reset_i),
      .req_i      (req_i),
      .addr_i     (addr_i),
      .ack_o      (ack_o),
      .data_o     (data_o),
      .flush_i    (flush_i),
      .mem_addr_o (mem_addr_o),
      .mem_load_o (mem_load_o),
      .mem_store_o(mem_store_o),
      .mem_data_o (mem_data_o),
      .mem_data_i (mem_data_i),
      .mem_done_i (mem_done_i),
      .hit_cnt_o  (hit_cnt_o),
      .miss_cnt_o (miss_cnt_o)
   );

   int          checks = 0;
   int          failures = 0;
   logic        chk_en = 1'b0;

   logic        e_ack, e_load;
   logic [31:0] e_data, e_addr, e_hit, e_miss;
   logic        m_valid [NL];
   logic [31:0] m_laddr [NL];

   logic [31:0] last_ack_data, last_load_addr;
   int          load_cycles = 0;
   int          lc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents: line 1 holds 0xA..0xD, other lines are distinct per address.
   function automatic logic [31:0] mem_word(input logic [31:0] la, input int unsigned k);
      return ((la ^ 32'd1) << 8) + 32'hA + k;
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      l = '0;
      for (int unsigned k = 0; k < NW; k++) l[k*32 +: 32] = mem_word(la, k);
      return l;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("ack_o", {31'd0, ack_o}, {31'd0, e_ack});
         check("data_o", data_o, e_data);
         check("mem_load_o", {31'd0, mem_load_o}, {31'd0, e_load});
         check("mem_addr_o", mem_addr_o, e_addr);
         check("hit_cnt_o", hit_cnt_o, e_hit);
         check("miss_cnt_o", miss_cnt_o, e_miss);
         check("mem_store_o", {31'd0, mem_store_o}, 32'd0);
         if (ack_o) last_ack_data = data_o;
         if (mem_load_o) begin
            load_cycles++;
            last_load_addr = mem_addr_o;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_flush();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
   endtask

   // One fetch; lat = cycles from request to mem_done_i, flush_at = cycle of flush pulse (-1 none).
   task automatic access(input logic [31:0] a, input int lat, input int flush_at);
      logic [31:0] la;
      int          idx, ws;
      logic        hit, pend;
      la   = a >> 4;
      idx  = int'((a >> 4) & (NL - 1));
      ws   = int'((a >> 2) & 3);
      pend = 1'b0;
      req_i   = 1'b1;
      addr_i  = a;
      flush_i = (flush_at == 0);
      hit     = !flush_i && m_valid[idx] && (m_laddr[idx] == la);
      e_ack   = hit;
      e_data  = hit ? mem_word(la, ws) : 32'd0;
      e_load  = 1'b0;
      step();
      flush_i = 1'b0;
      if (flush_at == 0) model_flush();
      if (hit) begin
         e_hit++;
         req_i  = 1'b0;
         e_ack  = 1'b0;
         e_data = 32'd0;
         return;
      end
      e_miss++;
      e_addr = la;
      e_load = 1'b1;
      e_ack  = 1'b0;
      e_data = 32'd0;
      for (int c = 1; c <= lat; c++) begin
         flush_i = (flush_at == c);
         if (flush_i) pend = 1'b1;
         if (c == lat) begin
            mem_done_i = 1'b1;
            mem_data_i = mem_line(la);
            e_ack      = 1'b1;
            e_data     = mem_word(la, ws);
         end else begin
            mem_data_i = {4{32'hDEAD_BEEF}};
         end
         step();
      end
      flush_i    = 1'b0;
      mem_done_i = 1'b0;
      req_i      = 1'b0;
      m_laddr[idx] = la;
      m_valid[idx] = !pend;
      if (pend) model_flush();
      e_load = 1'b0;
      e_ack  = 1'b0;
      e_data = 32'd0;
   endtask

   task automatic flush_pulse();
      req_i   = 1'b0;
      flush_i = 1'b1;
      e_ack   = 1'b0;
      e_data  = 32'd0;
      step();
      flush_i = 1'b0;
      model_flush();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i    = 1'b1;
      req_i      = 1'b0;
      addr_i     = '0;
      flush_i    = 1'b0;
      mem_done_i = 1'b0;
      mem_data_i = '0;
      model_flush();
      for (int i = 0; i < NL; i++) m_laddr[i] = '0;
      e_ack = 1'b0; e_load = 1'b0; e_data = '0; e_addr = '0; e_hit = '0; e_miss = '0;
      last_ack_data = '0; last_load_addr = '0;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      chk_en  = 1'b1;
      step();

      // basic miss then same-line hit
      access(32'h10, 3, -1);
      check("lit_refill_addr", last_load_addr, 32'h1);
      check("lit_miss_data", last_ack_data, 32'hA);
      access(32'h14, 1, -1);
      check("lit_hit_data", last_ack_data, 32'hB);
      check("lit_hit_cnt1", hit_cnt_o, 32'd1);
      check("lit_miss_cnt1", miss_cnt_o, 32'd1);

      // conflict on index 1
      access(32'h110, 2, -1);
      check("lit_conflict_addr", last_load_addr, 32'h11);
      check("lit_conflict_data", last_ack_data, 32'h100A);
      access(32'h10, 2, -1);
      check("lit_miss_cnt3", miss_cnt_o, 32'd3);

      // flush while idle
      flush_pulse();
      lc = load_cycles;
      access(32'h10, 2, -1);
      check("lit_reload_cycles", load_cycles - lc, 32'd2);
      check("lit_miss_cnt4", miss_cnt_o, 32'd4);

      // flush during refill of line 2, then request coinciding with a flush
      access(32'h28, 3, 2);
      check("lit_flush_refill_data", last_ack_data, 32'h30C);
      access(32'h20, 2, -1);
      check("lit_miss_cnt6", miss_cnt_o, 32'd6);
      access(32'h10, 1, 0);
      check("lit_miss_cnt7", miss_cnt_o, 32'd7);
      check("lit_hit_cnt_still1", hit_cnt_o, 32'd1);

      // reset two cycles into a refill, then a stray done
      req_i  = 1'b1;
      addr_i = 32'h30;
      step();
      e_miss++; e_addr = 32'h3; e_load = 1'b1;
      step();
      reset_i = 1'b1;
      req_i   = 1'b0;
      step();
      reset_i = 1'b0;
      model_flush();
      e_hit = '0; e_miss = '0; e_addr = '0; e_load = 1'b0;
      mem_done_i = 1'b1;
      mem_data_i = mem_line(32'h3);
      step();
      mem_done_i = 1'b0;
      step();
      check("lit_rst_hit", hit_cnt_o, 32'd0);
      check("lit_rst_miss", miss_cnt_o, 32'd0);
      check("lit_rst_load", {31'd0, mem_load_o}, 32'd0);

      // 100 alternating hits after one fill
      access(32'h0, 2, -1);
      lc = load_cycles;
      for (int i = 0; i < 100; i++) access((i % 2) ? 32'h4 : 32'h0, 1, -1);
      check("lit_loop_hit", hit_cnt_o, 32'd100);
      check("lit_loop_miss", miss_cnt_o, 32'd1);
      check("lit_loop_noload", load_cycles - lc, 32'd0);
      check("lit_loop_data", last_ack_data, 32'h10B);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
